// File: rtl/hilo_seq.sv
`timescale 1ns/1ps
// hilo_seq: sequences the multi-cycle div and mult units for the control FSM
// and holds the architectural HI/LO pair (mfhi/mflo read, mthi/mtlo write).
module hilo_seq #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_div,
    input  logic        start_mult,
    input  logic        div_done,
    input  logic        div0,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        mult_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    input  logic        rd_sel,
    output logic        div_ctrl,
    output logic        mult_ctrl,
    output logic        busy,
    output logic        op_done,
    output logic        div0_exc,
    output logic        timeout_err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {IDLE, DIV_RUN, MULT_RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             unit_div_q, unit_div_d;   // which unit DRAIN waits on
    logic             div_ctrl_q, div_ctrl_d;
    logic             mult_ctrl_q, mult_ctrl_d;
    logic             busy_q, busy_d;
    logic             op_done_q, op_done_d;
    logic             div0_exc_q, div0_exc_d;
    logic             timeout_err_q, timeout_err_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             tmo_hit;

    // Next-state, counter, capture and mthi/mtlo write decisions.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        unit_div_d    = unit_div_q;
        div_ctrl_d    = div_ctrl_q;
        mult_ctrl_d   = mult_ctrl_q;
        op_done_d     = 1'b0;
        div0_exc_d    = 1'b0;
        timeout_err_d = 1'b0;
        // mthi/mtlo land first so a capture on the same edge overrides them.
        hi_d          = wr_hi ? wr_data : hi_q;
        lo_d          = wr_lo ? wr_data : lo_q;
        // The counter holds completed RUN cycles; the incremented value
        // counts the current one, so RUN lasts exactly TIMEOUT cycles.
        cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
        tmo_hit       = (TIMEOUT != 0) && (cnt_inc == TMO_LIM);

        case (state_q)
            IDLE: begin
                if (start_div) begin
                    state_d    = DIV_RUN;
                    div_ctrl_d = 1'b1;
                    unit_div_d = 1'b1;
                    cnt_d      = '0;
                end else if (start_mult) begin
                    state_d     = MULT_RUN;
                    mult_ctrl_d = 1'b1;
                    unit_div_d  = 1'b0;
                    cnt_d       = '0;
                end
            end
            DIV_RUN: begin
                cnt_d = cnt_inc;
                if (div_done) begin
                    div_ctrl_d = 1'b0;
                    state_d    = DRAIN;
                    if (div0) begin
                        div0_exc_d = 1'b1;
                    end else begin
                        hi_d = div_hi;
                        lo_d = div_lo;
                    end
                end else if (tmo_hit) begin
                    div_ctrl_d    = 1'b0;
                    state_d       = DRAIN;
                    timeout_err_d = 1'b1;
                end
            end
            MULT_RUN: begin
                cnt_d = cnt_inc;
                if (mult_done) begin
                    mult_ctrl_d = 1'b0;
                    state_d     = DRAIN;
                    hi_d        = mult_hi;
                    lo_d        = mult_lo;
                end else if (tmo_hit) begin
                    mult_ctrl_d   = 1'b0;
                    state_d       = DRAIN;
                    timeout_err_d = 1'b1;
                end
            end
            DRAIN: begin
                // Wait for the unit to drop done so a stale done can never
                // retire the next operation early.
                if (!(unit_div_q ? div_done : mult_done)) begin
                    state_d   = IDLE;
                    op_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops ctrl lines and clears HI/LO at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            unit_div_q    <= 1'b0;
            div_ctrl_q    <= 1'b0;
            mult_ctrl_q   <= 1'b0;
            busy_q        <= 1'b0;
            op_done_q     <= 1'b0;
            div0_exc_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            unit_div_q    <= unit_div_d;
            div_ctrl_q    <= div_ctrl_d;
            mult_ctrl_q   <= mult_ctrl_d;
            busy_q        <= busy_d;
            op_done_q     <= op_done_d;
            div0_exc_q    <= div0_exc_d;
            timeout_err_q <= timeout_err_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
        end
    end

    assign div_ctrl    = div_ctrl_q;
    assign mult_ctrl   = mult_ctrl_q;
    assign busy        = busy_q;
    assign op_done     = op_done_q;
    assign div0_exc    = div0_exc_q;
    assign timeout_err = timeout_err_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign rd_data     = rd_sel ? hi_q : lo_q;

endmodule

// File: doc/hilo_seq.md
Name: hilo_seq

Overview:
- Sequencer and architectural HI/LO register pair between the main control FSM and the multi-cycle div and mult units.
- On a start request it holds the selected unit's control line high until that unit reports done. It then captures the unit's HI/LO results and reports completion to the control FSM.
- It also raises the divide-by-zero exception and provides the mfhi/mflo read path and the mthi/mtlo write path.

Parameters:
TIMEOUT, 0, maximum cycles in a RUN state before abort; 0 disables the timeout.
CNT_W, 32, width of the cycle counter; TIMEOUT must fit in CNT_W bits.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start_div  input  1  one-cycle request from the control FSM to run the divide
start_mult  input  1  one-cycle request from the control FSM to run the multiply
div_done  input  1  done flag from the div unit
div0  input  1  divide-by-zero flag from the div unit
div_hi  input  32  remainder from the div unit
div_lo  input  32  quotient from the div unit
mult_done  input  1  done flag from the mult unit
mult_hi  input  32  product[63:32] from the mult unit
mult_lo  input  32  product[31:0] from the mult unit
wr_hi  input  1  mthi strobe
wr_lo  input  1  mtlo strobe
wr_data  input  32  source operand for mthi/mtlo
rd_sel  input  1  read select: 1 = HI, 0 = LO
div_ctrl  output  1  held high to the div unit while a divide runs
mult_ctrl  output  1  held high to the mult unit while a multiply runs
busy  output  1  high in every state except IDLE; the control FSM stalls on it
op_done  output  1  one-cycle pulse when the operation has fully retired
div0_exc  output  1  one-cycle pulse on divide by zero
timeout_err  output  1  one-cycle pulse when a RUN state is aborted by the timeout
hi  output  32  architectural HI register
lo  output  32  architectural LO register
rd_data  output  32  combinational: hi when rd_sel = 1, else lo

Behaviour:
- Reset (asynchronous): state = IDLE; hi = lo = 0; counter = 0; all 1-bit outputs = 0. Reset mid-operation drops div_ctrl/mult_ctrl immediately and discards the in-flight result.
- All outputs except rd_data are registered.
- States: IDLE, DIV_RUN, MULT_RUN, DRAIN.
- IDLE:
  - start_div -> DIV_RUN; div_ctrl = 1 from the next cycle.
  - start_mult -> MULT_RUN; mult_ctrl = 1 from the next cycle.
  - If both are asserted, start_div wins and start_mult is dropped.
  - Counter cleared on entry to either RUN state.
- DIV_RUN:
  - Counter increments each cycle while div_ctrl is held high.
  - Done taken when div_done = 1 is sampled:
    - div0 = 1: div0_exc pulses; hi/lo are unchanged.
    - div0 = 0: hi <= div_hi, lo <= div_lo on that edge.
  - On the done edge, div_ctrl <= 0 and the state goes to DRAIN.
  - TIMEOUT != 0 and counter == TIMEOUT with no done: timeout_err pulses, hi/lo unchanged, state goes to DRAIN.
- MULT_RUN: identical to DIV_RUN using mult_done, mult_hi and mult_lo. No exception path.
- DRAIN:
  - Both ctrl lines are low.
  - Stays in DRAIN until the active unit's done flag reads 0. The units clear done one cycle after their ctrl line falls, so DRAIN lasts at least 1 cycle.
  - On exit: op_done pulses and the state returns to IDLE.
  - start_* requests arriving while busy are ignored and not queued.
- mthi/mtlo:
  - wr_hi writes hi and wr_lo writes lo, in any state.
  - If a capture writes the same register on the same edge, the capture wins.
  - wr_hi and wr_lo together write both registers.
- Latency: divide/multiply takes unit latency + 2 cycles from start to op_done (1 cycle start-to-ctrl plus 1 DRAIN cycle). busy rises the cycle after start and falls together with the op_done pulse.
- Counter saturates at all-ones and does not wrap.
- op_done pulses after a timeout as well as after div0. div0_exc and op_done are never high in the same cycle.

Test Plan:
- Divide 7 / 2 (div unit model: done after 4 cycles) -> hi = 1, lo = 3; one op_done pulse; div_ctrl high for exactly 4 cycles.
- Divide 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; no div0_exc.
- Divide by 0 with hi = 0x11, lo = 0x22 preloaded via mthi/mtlo -> div0_exc pulse, hi/lo stay 0x11/0x22, then op_done.
- Multiply 0x00010000 * 0x00010000 -> hi = 0x1, lo = 0x0. Same-cycle start_div and start_mult -> only div_ctrl rises.
- TIMEOUT = 8 with div_done stuck at 0 -> timeout_err on the 8th RUN cycle, then DRAIN, op_done, IDLE.
- wr_lo = 1 with 0xAA on the capture edge of a divide producing lo = 3 -> lo = 3. Reset asserted mid-DIV_RUN -> div_ctrl = 0 and hi/lo = 0 immediately.
